bp_fe_icache_mem_arbiter: RTL

Shares the icache data/tag/stat memory write ports between two requesters: port 0, the LCE command engine (coherence fills, invalidates, set clears, transfer reads), and port 1, the fetch pipeline (LRU stat updates and uncached writes). Each requester presents a bundle of up to three packets. The bundle is granted atomically: every requested channel or none. Port 0 has fixed priority, and a starvation counter guarantees port 1 forward progress. A lock lets one requester hold the memories across consecutive cycles, for example a transfer read followed by its send.

---
 rtl/bp_fe_icache_mem_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/bp_fe_icache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bp_fe_icache_mem_arbiter
// Purpose  : Shares the icache data/tag/stat memory write ports between the
//            LCE command engine (port 0) and the fetch pipeline (port 1).
//            Each port presents a bundle of up to three packets. A bundle is
//            granted atomically (all of its requested channels or none).
//            Port 0 has fixed priority. A saturating starvation counter
//            guarantees that port 1 makes forward progress. A lock lets the
//            current winner hold the memories over consecutive cycles.
// Ports    : clk_i, reset_n_i           - clock, async active-low reset
//            req_{data,tag,stat}_pkt_i  - per-port packets, port p at [p*w+:w]
//            req_{data,tag,stat}_v_i    - per-port channel requests
//            req_lock_i                 - per-port lock request
//            req_{data,tag,stat}_yumi_o - per-port packet consumed
//            {data,tag,stat}_mem_pkt_o  - selected packet to the memory
//            {data,tag,stat}_mem_pkt_v_o- packet valid to the memory
//            {data,tag,stat}_mem_ready_i- memory accepts this cycle
//            lock_owner_o               - one-hot lock holder, 0 if unlocked
// Revision : 1.0 - initial release
// ============================================================================
module bp_fe_icache_mem_arbiter #(
   parameter int data_pkt_width_p = 1,
   parameter int tag_pkt_width_p  = 1,
   parameter int stat_pkt_width_p = 1,
   parameter int max_starve_p     = 4
) (
   input  logic                          clk_i,
   input  logic                          reset_n_i,
   input  logic [2*data_pkt_width_p-1:0] req_data_pkt_i,
   input  logic [1:0]                    req_data_v_i,
   input  logic [2*tag_pkt_width_p-1:0]  req_tag_pkt_i,
   input  logic [1:0]                    req_tag_v_i,
   input  logic [2*stat_pkt_width_p-1:0] req_stat_pkt_i,
   input  logic [1:0]                    req_stat_v_i,
   input  logic [1:0]                    req_lock_i,
   output logic [1:0]                    req_data_yumi_o,
   output logic [1:0]                    req_tag_yumi_o,
   output logic [1:0]                    req_stat_yumi_o,
   output logic [data_pkt_width_p-1:0]   data_mem_pkt_o,
   output logic                          data_mem_pkt_v_o,
   input  logic                          data_mem_ready_i,
   output logic [tag_pkt_width_p-1:0]    tag_mem_pkt_o,
   output logic                          tag_mem_pkt_v_o,
   input  logic                          tag_mem_ready_i,
   output logic [stat_pkt_width_p-1:0]   stat_mem_pkt_o,
   output logic                          stat_mem_pkt_v_o,
   input  logic                          stat_mem_ready_i,
   output logic [1:0]                    lock_owner_o
);

   localparam logic [7:0] c_max_starve = 8'(max_starve_p);
   localparam logic [7:0] c_cnt_max    = 8'hFF;

   logic [1:0] r_lock_owner;
   logic [7:0] r_starve_cnt;

   logic [1:0] w_active;
   logic [1:0] w_elig;
   logic [1:0] w_lock;
   logic       w_sel_v;
   logic       w_sel;
   logic       w_gnt;
   logic [1:0] w_win_oh;

   assign w_active = req_data_v_i | req_tag_v_i | req_stat_v_i;

   // A port is eligible only if every channel it requests is ready, which is
   // what makes the bundle grant atomic.
   assign w_elig = w_active
                 & (~req_data_v_i | {2{data_mem_ready_i}})
                 & (~req_tag_v_i  | {2{tag_mem_ready_i}})
                 & (~req_stat_v_i | {2{stat_mem_ready_i}});

   // The lock is only in force while its owner keeps req_lock_i high; dropping
   // it releases the memories in the same cycle.
   assign w_lock = r_lock_owner & req_lock_i;

   always_comb begin
      w_sel_v = 1'b0;
      w_sel   = 1'b0;
      if (w_lock != 2'b00) begin
         if ((w_lock & w_elig) != 2'b00) begin
            w_sel_v = 1'b1;
            w_sel   = w_lock[1];
         end
      end else if ((r_starve_cnt >= c_max_starve) && w_elig[1]) begin
         w_sel_v = 1'b1;
         w_sel   = 1'b1;
      end else if (w_elig[0]) begin
         w_sel_v = 1'b1;
         w_sel   = 1'b0;
      end else if (w_elig[1]) begin
         w_sel_v = 1'b1;
         w_sel   = 1'b1;
      end
   end

   // Reset forces the whole output side idle without waiting for a clock.
   assign w_gnt    = w_sel_v & reset_n_i;
   assign w_win_oh = w_gnt ? {w_sel, ~w_sel} : 2'b00;

   assign req_data_yumi_o = w_win_oh & req_data_v_i;
   assign req_tag_yumi_o  = w_win_oh & req_tag_v_i;
   assign req_stat_yumi_o = w_win_oh & req_stat_v_i;

   assign data_mem_pkt_v_o = |req_data_yumi_o;
   assign tag_mem_pkt_v_o  = |req_tag_yumi_o;
   assign stat_mem_pkt_v_o = |req_stat_yumi_o;

   assign data_mem_pkt_o = !w_gnt ? '0 :
      (w_sel ? req_data_pkt_i[data_pkt_width_p +: data_pkt_width_p]
             : req_data_pkt_i[0 +: data_pkt_width_p]);
   assign tag_mem_pkt_o  = !w_gnt ? '0 :
      (w_sel ? req_tag_pkt_i[tag_pkt_width_p +: tag_pkt_width_p]
             : req_tag_pkt_i[0 +: tag_pkt_width_p]);
   assign stat_mem_pkt_o = !w_gnt ? '0 :
      (w_sel ? req_stat_pkt_i[stat_pkt_width_p +: stat_pkt_width_p]
             : req_stat_pkt_i[0 +: stat_pkt_width_p]);

   assign lock_owner_o = r_lock_owner;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_lock_owner <= 2'b00;
         r_starve_cnt <= 8'd0;
      end else begin
         // A winner asking for the lock takes it; otherwise an active lock
         // persists only while its owner keeps asking for it.
         if (w_gnt && req_lock_i[w_sel]) begin
            r_lock_owner <= w_win_oh;
         end else begin
            r_lock_owner <= w_lock;
         end

         // Counts only real port-0 wins against an active port 1, so cycles
         // spent waiting on an idle lock holder do not advance it.
         if (w_gnt && w_sel) begin
            r_starve_cnt <= 8'd0;
         end else if (w_gnt && !w_sel && w_active[1] && (r_starve_cnt != c_cnt_max)) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
         end
      end
   end

endmodule
`default_nettype wire
